// File: rtl/length_checksum_verify.sv
// length_checksum_verify
// Ingress-side check of payload length and 16-bit ones-complement checksum.
// The AXI stream passes through one register stage unchanged; each packet
// produces one pass/fail result on a valid/ready side channel.
//
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   axis_in_*                 ingress stream from decap (tready is combinational)
//   axis_out_*                registered copy of the ingress stream
//   meta_expected_length      header payload byte count, taken on the first beat
//   meta_checksum_seed        pseudo-header partial sum, taken on the first beat
//   meta_checksum_en          0 = packet carries no checksum, taken on the first beat
//   result_valid/ready        result handshake
//   result_length             counted byte length
//   result_checksum           final ones-complement sum
//   result_length_ok          counted length equals expected length
//   result_checksum_ok        sum is 16'hFFFF or checksum disabled
module length_checksum_verify #(
    parameter int unsigned AXIS_BUS_WIDTH   = 64,
    parameter int unsigned AXIS_TUSER_WIDTH = 4,
    parameter bit          CHECK_LENGTH     = 1'b1,
    parameter bit          CHECK_CHECKSUM   = 1'b1
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
    input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_tuser,
    input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep,
    input  logic                          axis_in_tlast,
    input  logic                          axis_in_tvalid,
    output logic                          axis_in_tready,

    output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
    output logic [AXIS_TUSER_WIDTH-1:0]   axis_out_tuser,
    output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
    output logic                          axis_out_tlast,
    output logic                          axis_out_tvalid,
    input  logic                          axis_out_tready,

    input  logic [15:0]                   meta_expected_length,
    input  logic [15:0]                   meta_checksum_seed,
    input  logic                          meta_checksum_en,

    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [15:0]                   result_length,
    output logic [15:0]                   result_checksum,
    output logic                          result_length_ok,
    output logic                          result_checksum_ok
);

    localparam int unsigned NUM_BUS_BYTES = AXIS_BUS_WIDTH / 8;
    localparam int unsigned NUM_LANES     = AXIS_BUS_WIDTH / 16;

    // 16-bit add with the carry folded back in (end-around carry).
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    logic                      in_packet;
    logic [15:0]               count;
    logic [15:0]               acc;
    logic [15:0]               exp_len_q;
    logic                      cks_en_q;

    logic                      accept;
    logic                      first;
    logic [AXIS_BUS_WIDTH-1:0] masked;
    logic [15:0]               beat_sum;
    logic [15:0]               beat_len;
    logic [15:0]               next_count;
    logic [15:0]               next_acc;
    logic [15:0]               exp_len;
    logic                      cks_en;
    logic                      len_ok;
    logic                      cks_ok;

    // Only a last beat waits for a pending result; earlier beats keep flowing.
    assign axis_in_tready = (!axis_out_tvalid || axis_out_tready)
                            && !(axis_in_tlast && result_valid && !result_ready);
    assign accept         = axis_in_tvalid && axis_in_tready;
    assign first          = !in_packet;

    // Zero bytes whose keep bit is clear.
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(NUM_BUS_BYTES); i++) begin
            masked[8*i +: 8] = axis_in_tkeep[i] ? axis_in_tdata[8*i +: 8] : 8'h00;
        end
    end

    // Lane k word is {byte 2k, byte 2k+1} with byte 2k as the high byte.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            beat_sum = ones_add(beat_sum, {masked[16*k +: 8], masked[16*k+8 +: 8]});
        end
    end

    // Last beat contributes the index of the lowest cleared keep bit.
    always_comb begin
        beat_len = 16'(NUM_BUS_BYTES);
        if (axis_in_tlast) begin
            for (int i = int'(NUM_BUS_BYTES) - 1; i >= 0; i--) begin
                if (!axis_in_tkeep[i]) begin
                    beat_len = 16'(i);
                end
            end
        end
    end

    // First beat restarts from zero / the seed and uses live metadata.
    always_comb begin
        next_count = (first ? 16'd0 : count) + beat_len;
        next_acc   = ones_add(first ? meta_checksum_seed : acc, beat_sum);
        exp_len    = first ? meta_expected_length : exp_len_q;
        cks_en     = first ? meta_checksum_en : cks_en_q;
        len_ok     = !CHECK_LENGTH || (next_count == exp_len);
        cks_ok     = !CHECK_CHECKSUM || !cks_en || (next_acc == 16'hFFFF);
    end

    // Stream register, packet accumulators and result register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            axis_out_tdata     <= '0;
            axis_out_tuser     <= '0;
            axis_out_tkeep     <= '0;
            axis_out_tlast     <= 1'b0;
            axis_out_tvalid    <= 1'b0;
            in_packet          <= 1'b0;
            count              <= '0;
            acc                <= '0;
            exp_len_q          <= '0;
            cks_en_q           <= 1'b0;
            result_valid       <= 1'b0;
            result_length      <= '0;
            result_checksum    <= '0;
            result_length_ok   <= 1'b0;
            result_checksum_ok <= 1'b0;
        end else begin
            if (accept) begin
                axis_out_tdata  <= axis_in_tdata;
                axis_out_tuser  <= axis_in_tuser;
                axis_out_tkeep  <= axis_in_tkeep;
                axis_out_tlast  <= axis_in_tlast;
                axis_out_tvalid <= 1'b1;
            end else if (axis_out_tready) begin
                axis_out_tvalid <= 1'b0;
            end

            if (accept) begin
                count     <= next_count;
                acc       <= next_acc;
                exp_len_q <= exp_len;
                cks_en_q  <= cks_en;
                in_packet <= !axis_in_tlast;
            end

            if (accept && axis_in_tlast) begin
                result_valid       <= 1'b1;
                result_length      <= CHECK_LENGTH ? next_count : 16'd0;
                result_checksum    <= CHECK_CHECKSUM ? next_acc : 16'd0;
                result_length_ok   <= len_ok;
                result_checksum_ok <= cks_ok;
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_length_checksum_verify.sv
// Testbench for length_checksum_verify: directed packets with hand-computed
// results, a stalled-result scenario, a mid-packet reset, and 100 random packets
// under random back-pressure, all checked cycle by cycle against a packet-level model.
module tb_length_checksum_verify;

    localparam int unsigned W  = 64;
    localparam int unsigned U  = 4;
    localparam int unsigned NB = W / 8;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [NB-1:0] keep;
        logic [U-1:0]  user;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic [W-1:0]  axis_in_tdata;
    logic [U-1:0]  axis_in_tuser;
    logic [NB-1:0] axis_in_tkeep;
    logic          axis_in_tlast;
    logic          axis_in_tvalid;
    logic          axis_in_tready;
    logic [W-1:0]  axis_out_tdata;
    logic [U-1:0]  axis_out_tuser;
    logic [NB-1:0] axis_out_tkeep;
    logic          axis_out_tlast;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic [15:0]   meta_expected_length;
    logic [15:0]   meta_checksum_seed;
    logic          meta_checksum_en;
    logic          result_valid;
    logic          result_ready;
    logic [15:0]   result_length;
    logic [15:0]   result_checksum;
    logic          result_length_ok;
    logic          result_checksum_ok;

    int tests = 0;
    int fails = 0;
    int otr_mode = 1;   // 0 random, 1 high, 2 low
    int rr_mode  = 1;
    int pkts_sent = 0;
    int results_seen = 0;

    beat_t pkt_q[$];
    beat_t rb;

    length_checksum_verify #(
        .AXIS_BUS_WIDTH(W), .AXIS_TUSER_WIDTH(U), .CHECK_LENGTH(1'b1), .CHECK_CHECKSUM(1'b1)
    ) dut (
        .aclk(aclk), .areset(areset),
        .axis_in_tdata(axis_in_tdata), .axis_in_tuser(axis_in_tuser),
        .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tuser(axis_out_tuser),
        .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .meta_expected_length(meta_expected_length), .meta_checksum_seed(meta_checksum_seed),
        .meta_checksum_en(meta_checksum_en),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_length(result_length), .result_checksum(result_checksum),
        .result_length_ok(result_length_ok), .result_checksum_ok(result_checksum_ok)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic int lane_sum(input logic [W-1:0] d, input logic [NB-1:0] k);
        int s;
        logic [7:0] hi;
        logic [7:0] lo;
        s = 0;
        for (int j = 0; j < int'(NB); j += 2) begin
            hi = k[j]   ? d[8*j +: 8]   : 8'h00;
            lo = k[j+1] ? d[8*j+8 +: 8] : 8'h00;
            s += int'({hi, lo});
        end
        return s;
    endfunction

    function automatic logic [15:0] fold16(input longint unsigned t);
        longint unsigned v;
        v = t;
        while (v > 64'hFFFF) v = (v & 64'hFFFF) + (v >> 16);
        return 16'(v);
    endfunction

    function automatic int low_zero(input logic [NB-1:0] k);
        for (int i = 0; i < int'(NB); i++) if (!k[i]) return i;
        return int'(NB);
    endfunction

    function automatic longint unsigned pkt_sum();
        longint unsigned s;
        s = 0;
        foreach (pkt_q[i]) s += longint'(lane_sum(pkt_q[i].data, pkt_q[i].keep));
        return s;
    endfunction

    // ---------------- cycle model + compare ----------------
    bit              m_live = 0;
    logic            m_ov = 0, m_ol = 0, m_rv = 0, m_lok = 0, m_cok = 0;
    logic [W-1:0]    m_od = '0;
    logic [U-1:0]    m_ou = '0;
    logic [NB-1:0]   m_ok = '0;
    logic [15:0]     m_len = '0, m_cks = '0;
    bit              in_pkt = 0;
    logic [15:0]     p_seed, p_exp;
    logic            p_en;
    longint unsigned p_sum;
    int              p_beats;
    bit              acc_b;
    logic            exp_tready;

    always @(negedge aclk) begin
        if (m_live) begin
            check("out_tvalid", 64'(axis_out_tvalid), 64'(m_ov));
            if (m_ov) begin
                check("out_tdata", 64'(axis_out_tdata), 64'(m_od));
                check("out_tuser", 64'(axis_out_tuser), 64'(m_ou));
                check("out_tkeep", 64'(axis_out_tkeep), 64'(m_ok));
                check("out_tlast", 64'(axis_out_tlast), 64'(m_ol));
            end
            check("result_valid", 64'(result_valid), 64'(m_rv));
            if (m_rv) begin
                check("result_length", 64'(result_length), 64'(m_len));
                check("result_checksum", 64'(result_checksum), 64'(m_cks));
                check("result_length_ok", 64'(result_length_ok), 64'(m_lok));
                check("result_checksum_ok", 64'(result_checksum_ok), 64'(m_cok));
            end
            exp_tready = (!m_ov || axis_out_tready) && !(axis_in_tlast && m_rv && !result_ready);
            check("in_tready", 64'(axis_in_tready), 64'(exp_tready));
        end

        if (areset) begin
            m_live = 1; m_ov = 0; m_rv = 0; m_len = '0; m_cks = '0;
            m_lok = 0; m_cok = 0; in_pkt = 0;
        end else if (m_live) begin
            acc_b = axis_in_tvalid && axis_in_tready;
            if (m_rv && result_ready) results_seen++;
            if (!(acc_b && axis_in_tlast) && result_ready) m_rv = 0;
            if (acc_b) begin
                m_ov = 1; m_od = axis_in_tdata; m_ou = axis_in_tuser;
                m_ok = axis_in_tkeep; m_ol = axis_in_tlast;
                if (!in_pkt) begin
                    p_seed = meta_checksum_seed; p_exp = meta_expected_length;
                    p_en = meta_checksum_en; p_sum = 0; p_beats = 0;
                end
                p_sum += longint'(lane_sum(axis_in_tdata, axis_in_tkeep));
                if (axis_in_tlast) begin
                    m_len = 16'(p_beats * int'(NB) + low_zero(axis_in_tkeep));
                    m_cks = fold16(p_sum + 64'(p_seed));
                    m_lok = (m_len == p_exp);
                    m_cok = (m_cks == 16'hFFFF) || !p_en;
                    m_rv  = 1;
                    in_pkt = 0;
                end else begin
                    p_beats++;
                    in_pkt = 1;
                end
            end else if (axis_out_tready) begin
                m_ov = 0;
            end
        end
    end

    // ---------------- ready drivers ----------------
    initial begin
        axis_out_tready = 1'b1;
        result_ready    = 1'b1;
        forever begin
            @(posedge aclk); #1;
            axis_out_tready = (otr_mode == 0) ? 1'($urandom_range(0, 1)) : (otr_mode == 1);
            result_ready    = (rr_mode == 0)  ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_beat(input beat_t b, input logic last, input logic [15:0] exp,
                             input logic [15:0] seed, input logic en, input int budget);
        bit ok;
        axis_in_tdata = b.data; axis_in_tkeep = b.keep; axis_in_tuser = b.user;
        axis_in_tlast = last; axis_in_tvalid = 1'b1;
        meta_expected_length = exp; meta_checksum_seed = seed; meta_checksum_en = en;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge aclk);
            if (axis_in_tready) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        axis_in_tvalid = 1'b0;
        check("beat_accepted", 64'(ok), 64'd1);
        if (ok && last) pkts_sent++;
    endtask

    // Metadata on later beats is garbage; only the first beat's values count.
    task automatic send_pkt(input logic [15:0] exp, input logic [15:0] seed, input logic en, input int budget);
        int n;
        n = pkt_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == 0) send_beat(pkt_q[i], i == n - 1, exp, seed, en, budget);
            else send_beat(pkt_q[i], i == n - 1, 16'($urandom), 16'($urandom), 1'($urandom), budget);
        end
    endtask

    task automatic wait_result(input string tag, input int budget, input logic [15:0] len,
                               input logic [15:0] cks, input bit chk_cks, input logic lok, input logic cok);
        bit got;
        got = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge aclk);
            if (result_valid) begin got = 1; break; end
        end
        check({tag, "_present"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_length"}, 64'(result_length), 64'(len));
            if (chk_cks) check({tag, "_checksum"}, 64'(result_checksum), 64'(cks));
            check({tag, "_length_ok"}, 64'(result_length_ok), 64'(lok));
            check({tag, "_checksum_ok"}, 64'(result_checksum_ok), 64'(cok));
        end
        @(posedge aclk); #1;
    endtask

    task automatic build1();
        pkt_q.delete();
        pkt_q.push_back('{data: 64'hA5A5_A5A5_A5A5_3412, keep: 8'h03, user: 4'h5});
    endtask

    task automatic build3(input logic [63:0] flip);
        pkt_q.delete();
        pkt_q.push_back('{data: 64'h0807_0605_0403_0201, keep: 8'hFF, user: 4'h1});
        pkt_q.push_back('{data: 64'h100F_0E0D_0C0B_0A09 ^ flip, keep: 8'hFF, user: 4'h2});
        pkt_q.push_back('{data: 64'hEEEE_EEEE_1413_1211, keep: 8'h0F, user: 4'h3});
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] seed3;
    int          n;
    logic [15:0] exp_r, seed_r;

    initial begin
        areset = 1'b1; axis_in_tvalid = 1'b0; axis_in_tlast = 1'b0;
        axis_in_tdata = '0; axis_in_tkeep = '0; axis_in_tuser = '0;
        meta_expected_length = '0; meta_checksum_seed = '0; meta_checksum_en = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        @(negedge aclk);
        check("reset_result_valid", 64'(result_valid), 64'd0);
        check("reset_out_tvalid", 64'(axis_out_tvalid), 64'd0);
        check("reset_result_length", 64'(result_length), 64'd0);
        @(posedge aclk); #1;

        // 0x1234 + 0xEDCB = 0xFFFF, two bytes
        build1();
        send_pkt(16'd2, 16'hEDCB, 1'b1, 4);
        wait_result("single", 1, 16'd2, 16'hFFFF, 1, 1'b1, 1'b1);

        build3(64'd0);
        seed3 = ~fold16(pkt_sum());
        send_pkt(16'd20, seed3, 1'b1, 4);
        wait_result("p20", 1, 16'd20, 16'hFFFF, 1, 1'b1, 1'b1);

        build3(64'h0000_0000_00FF_0000);
        send_pkt(16'd20, seed3, 1'b1, 4);
        wait_result("p20_flip", 1, 16'd20, 16'h0, 0, 1'b1, 1'b0);

        build3(64'd0);
        send_pkt(16'd21, seed3, 1'b1, 4);
        wait_result("p21", 1, 16'd20, 16'hFFFF, 1, 1'b0, 1'b1);

        build3(64'h0000_0000_00FF_0000);
        send_pkt(16'd20, seed3, 1'b0, 4);
        wait_result("p20_noen", 1, 16'd20, 16'h0, 0, 1'b1, 1'b1);

        // Result A left pending; B's body flows, B's last beat stalls.
        rr_mode = 2;
        @(posedge aclk); #1;
        build1();
        send_pkt(16'd2, 16'hEDCB, 1'b1, 2);
        rb = '{data: 64'h1111_2222_3333_4444, keep: 8'hFF, user: 4'hA};
        send_beat(rb, 1'b0, 16'd24, 16'h0, 1'b0, 1);
        send_beat(rb, 1'b0, 16'h0, 16'h0, 1'b1, 1);
        axis_in_tdata = 64'h5555_6666_7777_8888; axis_in_tkeep = 8'hFF; axis_in_tuser = 4'hB;
        axis_in_tlast = 1'b1; axis_in_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("stall_tready", 64'(axis_in_tready), 64'd0);
            check("stall_a_length", 64'(result_length), 64'd2);
        end
        rr_mode = 1;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("release_tready", 64'(axis_in_tready), 64'd1);
        @(posedge aclk); #1;
        axis_in_tvalid = 1'b0;
        pkts_sent++;
        wait_result("stall_b", 1, 16'd24, 16'h0, 0, 1'b1, 1'b1);

        // Reset in the middle of a packet, then a fresh single beat.
        rb = '{data: 64'hFFFF_FFFF_FFFF_FFFF, keep: 8'hFF, user: 4'h7};
        send_beat(rb, 1'b0, 16'd99, 16'h1234, 1'b1, 4);
        send_beat(rb, 1'b0, 16'd0, 16'h0, 1'b1, 4);
        areset = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("rst_out_tvalid", 64'(axis_out_tvalid), 64'd0);
        check("rst_out_tdata", 64'(axis_out_tdata), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result_length", 64'(result_length), 64'd0);
        check("rst_result_checksum", 64'(result_checksum), 64'd0);
        check("rst_length_ok", 64'(result_length_ok), 64'd0);
        check("rst_checksum_ok", 64'(result_checksum_ok), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        build1();
        send_pkt(16'd2, 16'hEDCB, 1'b1, 4);
        wait_result("post_rst", 1, 16'd2, 16'hFFFF, 1, 1'b1, 1'b1);

        // Random packets under random back-pressure on both outputs.
        otr_mode = 0; rr_mode = 0;
        for (int p = 0; p < 100; p++) begin
            n = $urandom_range(1, 4);
            pkt_q.delete();
            for (int i = 0; i < n; i++) begin
                rb.data = {$urandom, $urandom};
                rb.keep = 8'($urandom);
                rb.user = 4'($urandom);
                if (i == n - 1 && $urandom_range(0, 1) == 1) rb.keep = 8'hFF;
                pkt_q.push_back(rb);
            end
            exp_r = 16'((n - 1) * int'(NB) + low_zero(pkt_q[n-1].keep));
            if ($urandom_range(0, 1) == 1) exp_r = 16'($urandom);
            seed_r = ($urandom_range(0, 1) == 1) ? ~fold16(pkt_sum()) : 16'($urandom);
            send_pkt(exp_r, seed_r, 1'($urandom), 400);
            repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        end

        otr_mode = 1; rr_mode = 1;
        repeat (10) begin @(posedge aclk); #1; end
        check("result_count", 64'(results_seen), 64'(pkts_sent));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog timeout");
    end

endmodule
